// File: rtl/branch_pc_unit_if.sv
// Bundles the fetch handshake, decoder branch/halt inputs and PC/status outputs of branch_pc_unit.
interface branch_pc_unit_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  logic               start;
  logic [PC_W-1:0]    startAddr;
  logic               imemAck;
  logic [INSTR_W-1:0] imemData;
  logic               branchEn;
  logic               branchType;
  logic [7:0]         branchOff;
  logic               zero;
  logic               haltReq;
  logic [PC_W-1:0]    pc;
  logic               imemReq;
  logic [INSTR_W-1:0] instr;
  logic               instrValid;
  logic               done;
  logic [CNT_W-1:0]   cycleCount;

  modport master (
    output start, startAddr, imemAck, imemData, branchEn, branchType, branchOff, zero, haltReq,
    input  pc, imemReq, instr, instrValid, done, cycleCount
  );

  modport slave (
    input  start, startAddr, imemAck, imemData, branchEn, branchType, branchOff, zero, haltReq,
    output pc, imemReq, instr, instrValid, done, cycleCount
  );
endinterface

// File: rtl/branch_pc_unit.sv
// Program counter sequencer: fetches one instruction at a time, resolves branches/halt in a
// single EXEC cycle and counts the cycles spent fetching and executing.
module branch_pc_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_pc_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  state_t             state;
  state_t             nextState;
  logic [PC_W-1:0]    pcReg;
  logic [INSTR_W-1:0] instrReg;
  logic               instrValidReg;
  logic [CNT_W-1:0]   cycleCountReg;
  logic [PC_W-1:0]    offExt;
  logic               taken;

  // Offset is sign-extended so negative displacements wrap modulo 2^PC_W.
  assign offExt = PC_W'($signed(bus.branchOff));
  assign taken  = bus.branchEn & (bus.branchType ? ~bus.zero : bus.zero);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE, DONE: if (bus.start) nextState = FETCH;
      FETCH:      if (bus.imemAck) nextState = EXEC;
      EXEC:       nextState = bus.haltReq ? DONE : FETCH;
      default:    nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcReg         <= '0;
      instrReg      <= '0;
      instrValidReg <= 1'b0;
      cycleCountReg <= '0;
    end else begin
      instrValidReg <= (state == FETCH) && bus.imemAck;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            pcReg         <= bus.startAddr;
            cycleCountReg <= '0;
          end
        end
        FETCH: begin
          if (cycleCountReg != '1) cycleCountReg <= cycleCountReg + CNT_W'(1);
          if (bus.imemAck) instrReg <= bus.imemData;
        end
        EXEC: begin
          if (cycleCountReg != '1) cycleCountReg <= cycleCountReg + CNT_W'(1);
          // Halt wins over a taken branch and freezes the PC on the halt instruction.
          if (!bus.haltReq) pcReg <= taken ? pcReg + offExt : pcReg + PC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.pc         = pcReg;
  assign bus.instr      = instrReg;
  assign bus.instrValid = instrValidReg;
  assign bus.cycleCount = cycleCountReg;
  assign bus.imemReq    = (state == FETCH);
  assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed scenarios plus randomized traffic against
// a cycle-level behavioural model of the program sequencer.
module tb_branch_pc_unit;
  localparam int PC_W    = 10;
  localparam int INSTR_W = 9;
  localparam int CNT_W   = 16;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_EXEC = 2, PH_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int   mPhase, mPc, mInstr, mValid, mCount;

  branch_pc_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) bus ();

  branch_pc_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mPhase = PH_IDLE; mPc = 0; mInstr = 0; mValid = 0; mCount = 0;
  endtask

  // Advance the model by one clock edge using the inputs as they stand before the edge.
  task automatic model_step();
    int nextPhase;
    int off;
    bit tk;
    nextPhase = mPhase;
    mValid = 0;
    if (rst) begin
      model_reset();
      return;
    end
    case (mPhase)
      PH_IDLE, PH_DONE: if (bus.start) begin
        mPc = int'(bus.startAddr); mCount = 0; nextPhase = PH_FETCH;
      end
      PH_FETCH: begin
        if (mCount < CNT_MAX) mCount++;
        if (bus.imemAck) begin
          mInstr = int'(bus.imemData); mValid = 1; nextPhase = PH_EXEC;
        end
      end
      default: begin
        if (mCount < CNT_MAX) mCount++;
        if (bus.haltReq) nextPhase = PH_DONE;
        else begin
          tk  = bus.branchEn && (bus.branchType ? !bus.zero : bus.zero);
          off = $signed(bus.branchOff);
          mPc = (((mPc + (tk ? off : 1)) % PC_MOD) + PC_MOD) % PC_MOD;
          nextPhase = PH_FETCH;
        end
      end
    endcase
    mPhase = nextPhase;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.startAddr = '0; bus.imemAck = 0; bus.imemData = '0;
    bus.branchEn = 0; bus.branchType = 0; bus.branchOff = '0; bus.zero = 0; bus.haltReq = 0;
  endtask

  task automatic pulse_reset();
    rst = 1;
    model_reset();
    tick();
    rst = 0;
    #1;
  endtask

  // Brings the DUT from IDLE into EXEC with the given PC.
  task automatic run_to_exec(input int addr);
    clear_inputs();
    bus.start = 1; bus.startAddr = PC_W'(addr);
    tick();
    bus.start = 0; bus.imemAck = 1; bus.imemData = INSTR_W'($urandom);
    tick();
    bus.imemAck = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    pulse_reset();
    checks++;
    if ({bus.pc, bus.instr, bus.instrValid, bus.imemReq, bus.done, bus.cycleCount} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got pc=%h instr=%h v=%b req=%b done=%b cnt=%0d required all 0",
               bus.pc, bus.instr, bus.instrValid, bus.imemReq, bus.done, bus.cycleCount);
    end
    bus.imemAck = 1;
    repeat (3) tick();
    checks++;
    if (bus.imemReq !== 1'b0 || bus.pc !== '0) begin
      errors++;
      $display("[TB] FAIL idle_hold: got req=%b pc=%h required req=0 pc=000", bus.imemReq, bus.pc);
    end
  endtask

  task automatic test_sequential();
    pulse_reset();
    bus.start = 1; bus.startAddr = 10'h010;
    tick();
    bus.start = 0; bus.imemAck = 1;
    for (int i = 0; i < 6; i++) begin
      bus.imemData = INSTR_W'($urandom);
      tick();
      checks++;
      if (bus.pc !== PC_W'(mPc) || bus.instrValid !== mValid[0] || bus.instr !== INSTR_W'(mInstr)) begin
        errors++;
        $display("[TB] FAIL seq_step%0d: got pc=%h v=%b instr=%h required pc=%h v=%0d instr=%h",
                 i, bus.pc, bus.instrValid, bus.instr, mPc, mValid, mInstr);
      end
    end
    checks++;
    if (bus.pc !== 10'h013 || bus.cycleCount !== 16'd6) begin
      errors++;
      $display("[TB] FAIL seq_final: got pc=%h cnt=%0d required pc=013 cnt=6", bus.pc, bus.cycleCount);
    end
  endtask

  task automatic test_branch();
    logic [PC_W-1:0] want [4] = '{10'h01C, 10'h021, 10'h001, 10'h000};
    int              base [4] = '{32'h020, 32'h020, 32'h3FF, 32'h3FF};
    for (int i = 0; i < 4; i++) begin
      pulse_reset();
      run_to_exec(base[i]);
      bus.branchEn   = (i != 3);
      bus.branchType = (i == 2);
      bus.zero       = (i == 0);
      bus.branchOff  = (i == 2) ? 8'h02 : 8'hFC;
      tick();
      checks++;
      if (bus.pc !== want[i] || bus.pc !== PC_W'(mPc)) begin
        errors++;
        $display("[TB] FAIL branch_case%0d: got pc=%h required %h (model %h)", i, bus.pc, want[i], mPc);
      end
    end
    pulse_reset();
    run_to_exec(32'h155);
    bus.branchEn = 1; bus.branchType = 1; bus.zero = 0; bus.branchOff = 8'h00;
    tick();
    checks++;
    if (bus.pc !== 10'h155) begin
      errors++;
      $display("[TB] FAIL self_loop: got pc=%h required 155", bus.pc);
    end
  endtask

  task automatic test_stall_halt();
    int cnt0;
    pulse_reset();
    clear_inputs();
    bus.start = 1; bus.startAddr = 10'h0A0;
    tick();
    bus.start = 0;
    cnt0 = int'(bus.cycleCount);
    repeat (5) tick();
    checks++;
    if (bus.imemReq !== 1'b1 || bus.pc !== 10'h0A0 || int'(bus.cycleCount) !== cnt0 + 5) begin
      errors++;
      $display("[TB] FAIL stall: got req=%b pc=%h cnt=%0d required req=1 pc=0a0 cnt=%0d",
               bus.imemReq, bus.pc, bus.cycleCount, cnt0 + 5);
    end
    bus.imemAck = 1;
    tick();
    bus.imemAck = 0;
    bus.haltReq = 1; bus.branchEn = 1; bus.branchType = 0; bus.zero = 1; bus.branchOff = 8'h10;
    tick();
    clear_inputs();
    repeat (3) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.pc !== 10'h0A0 || bus.cycleCount !== 16'd7 || bus.imemReq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt: got done=%b pc=%h cnt=%0d req=%b required done=1 pc=0a0 cnt=7 req=0",
               bus.done, bus.pc, bus.cycleCount, bus.imemReq);
    end
  endtask

  task automatic test_async_reset();
    pulse_reset();
    run_to_exec(32'h123);
    bus.imemAck = 1; bus.branchEn = 1; bus.zero = 1; bus.branchOff = 8'h05;
    #2;
    rst = 1;
    model_reset();
    #1;
    checks++;
    if ({bus.pc, bus.instr, bus.instrValid, bus.imemReq, bus.done, bus.cycleCount} !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got pc=%h instr=%h v=%b req=%b done=%b cnt=%0d required all 0",
               bus.pc, bus.instr, bus.instrValid, bus.imemReq, bus.done, bus.cycleCount);
    end
    @(posedge clk);
    #1;
    rst = 0;
    clear_inputs();
    bus.start = 1; bus.startAddr = 10'h200;
    tick();
    bus.startAddr = 10'h2FF;
    repeat (2) tick();
    checks++;
    if (bus.pc !== 10'h200 || bus.imemReq !== 1'b1 || bus.cycleCount !== 16'd2) begin
      errors++;
      $display("[TB] FAIL start_in_fetch: got pc=%h req=%b cnt=%0d required pc=200 req=1 cnt=2",
               bus.pc, bus.imemReq, bus.cycleCount);
    end
    bus.start = 0; bus.imemAck = 1;
    tick();
    bus.imemAck = 0; bus.haltReq = 1;
    tick();
    bus.haltReq = 0; bus.start = 1; bus.startAddr = 10'h040;
    tick();
    checks++;
    if (bus.pc !== 10'h040 || bus.cycleCount !== 16'd0 || bus.done !== 1'b0 || bus.imemReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_from_done: got pc=%h cnt=%0d done=%b req=%b required pc=040 cnt=0 done=0 req=1",
               bus.pc, bus.cycleCount, bus.done, bus.imemReq);
    end
    bus.start = 0;
  endtask

  task automatic test_random();
    pulse_reset();
    clear_inputs();
    for (int i = 0; i < 600; i++) begin
      bus.start      = ($urandom_range(0, 5) == 0);
      bus.startAddr  = ($urandom_range(0, 3) == 0) ? PC_W'(PC_MOD - 1 - $urandom_range(0, 2)) : PC_W'($urandom);
      bus.imemAck    = ($urandom_range(0, 2) != 0);
      bus.imemData   = INSTR_W'($urandom);
      bus.branchEn   = $urandom_range(0, 1);
      bus.branchType = $urandom_range(0, 1);
      bus.branchOff  = 8'($urandom);
      bus.zero       = $urandom_range(0, 1);
      bus.haltReq    = ($urandom_range(0, 9) == 0);
      tick();
      checks++;
      if (bus.pc !== PC_W'(mPc) || bus.instr !== INSTR_W'(mInstr) || bus.instrValid !== mValid[0] ||
          bus.imemReq !== (mPhase == PH_FETCH) || bus.done !== (mPhase == PH_DONE) ||
          bus.cycleCount !== CNT_W'(mCount)) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: got pc=%h instr=%h v=%b req=%b done=%b cnt=%0d required pc=%h instr=%h v=%0d req=%0d done=%0d cnt=%0d",
                 i, bus.pc, bus.instr, bus.instrValid, bus.imemReq, bus.done, bus.cycleCount,
                 mPc, mInstr, mValid, mPhase == PH_FETCH, mPhase == PH_DONE, mCount);
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    #2;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_halt();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, program-counter width.
REQ-002 The block SHALL have parameter INSTR_W, default 9, instruction width.
REQ-003 The block SHALL have parameter CNT_W, default 16, cycle-counter width.
REQ-004 The block SHALL have port CLK  input  1  sole clock, all state updates on rising edge.
REQ-005 The block SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port Start  input  1  begin program at StartAddr.
REQ-007 The block SHALL have port StartAddr  input  PC_W  program entry address.
REQ-008 The block SHALL have port ImemAck  input  1  instruction memory data valid.
REQ-009 The block SHALL have port ImemData  input  INSTR_W  fetched instruction word.
REQ-010 The block SHALL have port BranchEn  input  1  decoder flags current instruction as branch.
REQ-011 The block SHALL have port BranchType  input  1  0 = branch-equal (take on Zero=1), 1 = branch-true (take on Zero=0).
REQ-012 The block SHALL have port BranchOff  input  8  signed two's-complement PC offset.
REQ-013 The block SHALL have port Zero  input  1  ALU zero flag for current instruction.
REQ-014 The block SHALL have port HaltReq  input  1  decoder flags current instruction as halt.
REQ-015 The block SHALL have port PC  output  PC_W  current fetch address.
REQ-016 The block SHALL have port ImemReq  output  1  fetch request, asserted throughout FETCH.
REQ-017 The block SHALL have port Instr  output  INSTR_W  latched instruction.
REQ-018 The block SHALL have port InstrValid  output  1  one-cycle pulse when Instr is newly latched.
REQ-019 The block SHALL have port Done  output  1  program halted.
REQ-020 The block SHALL have port CycleCount  output  CNT_W  cycles spent executing.

Function
REQ-021 The FSM SHALL have states IDLE, FETCH, EXEC, DONE; ImemReq SHALL equal (state==FETCH), Done SHALL equal (state==DONE).
REQ-022 In IDLE or DONE, Start=1 SHALL load PC<=StartAddr, clear CycleCount, and go to FETCH next cycle.
REQ-023 Start SHALL be ignored in FETCH and EXEC.
REQ-024 In FETCH, ImemAck=1 SHALL latch Instr<=ImemData, pulse InstrValid for exactly the next cycle, and go to EXEC; ImemAck=0 SHALL hold FETCH indefinitely with PC stable.
REQ-025 ImemAck outside FETCH SHALL be ignored; Instr SHALL hold its value.
REQ-026 EXEC SHALL last exactly one cycle; BranchEn, BranchType, BranchOff, Zero, HaltReq SHALL be sampled only on the EXEC clock edge.
REQ-027 Branch taken = BranchEn & (BranchType ? ~Zero : Zero).
REQ-028 On EXEC exit without halt, PC SHALL become PC + sign-extended BranchOff if taken, else PC+1, both modulo 2^PC_W (wrap, no error).
REQ-029 A taken branch with BranchOff=0 SHALL leave PC unchanged (legal self-loop).
REQ-030 HaltReq=1 in EXEC SHALL go to DONE with PC unchanged; halt SHALL take priority over a simultaneous taken branch.
REQ-031 CycleCount SHALL increment by 1 on every edge in FETCH or EXEC and saturate at 2^CNT_W-1; it SHALL hold in IDLE and DONE.
REQ-032 Instruction latency SHALL be 2 cycles minimum (FETCH with immediate ack + EXEC).

Reset
REQ-033 Reset=1 SHALL immediately, independent of CLK, force state=IDLE, PC=0, Instr=0, InstrValid=0, ImemReq=0, Done=0, CycleCount=0.
REQ-034 Reset asserted mid-FETCH or mid-EXEC SHALL abandon the instruction with no PC update; a pending ImemAck SHALL be ignored.
REQ-035 After Reset deasserts, the block SHALL stay in IDLE until Start.

Verification
REQ-036 Start with StartAddr=0x010, ImemAck=1 every cycle, no branch/halt -> PC 0x010,0x011,0x012 each 2 cycles; InstrValid pulses every other cycle.
REQ-037 PC=0x020, BranchEn=1, BranchType=0, Zero=1, BranchOff=0xFC -> PC=0x01C; same with Zero=0 -> PC=0x021.
REQ-038 PC=0x3FF, BranchType=1, Zero=0, BranchOff=0x02 -> PC=0x001; PC=0x3FF no branch -> PC=0x000.
REQ-039 ImemAck held 0 for 5 cycles in FETCH -> ImemReq=1, PC stable, CycleCount +5; then HaltReq=1 with taken branch in EXEC -> Done=1, PC unchanged, CycleCount frozen.
REQ-040 Reset pulsed mid-EXEC (async, between edges) -> all outputs 0 immediately; Start ignored during FETCH; Start in DONE restarts with CycleCount=0.
